mem_rd_port_arbiter: RTL

- Shares one external memory read channel (start/addrs/lengths/data_req/data) between two burst requesters.
- Typical use: requester 0 is the B-offset accumulator, requester 1 is the non-uniformity correction B-table reader.
- Replaces the static busy-flag mux with latched requests, explicit grants and beat counting.
- A burst is released only after its full length has been transferred.

---
 rtl/mem_rd_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_rd_port_arbiter.sv
// Two-requester arbiter for a single burst memory read channel, with latched requests, grants and beat counting.
// Define MEM_RD_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority with requester 0 first.
module mem_rd_port_arbiter #(
  parameter int              ADDRS_DW  = 21,
  parameter int              DW        = 16,
  parameter logic [DW-1:0]   IDLE_DATA = 16'd0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req0_start,
  input  logic [ADDRS_DW-1:0] i_req0_addrs,
  input  logic [ADDRS_DW-1:0] i_req0_lengths,
  input  logic                i_req0_data_req,
  output logic [DW-1:0]       o_req0_data,
  output logic                o_req0_grant,
  input  logic                i_req1_start,
  input  logic [ADDRS_DW-1:0] i_req1_addrs,
  input  logic [ADDRS_DW-1:0] i_req1_lengths,
  input  logic                i_req1_data_req,
  output logic [DW-1:0]       o_req1_data,
  output logic                o_req1_grant,
  output logic                o_mem_rd_start,
  output logic [ADDRS_DW-1:0] o_mem_rd_addrs,
  output logic [ADDRS_DW-1:0] o_mem_rd_lengths,
  input  logic [DW-1:0]       i_mem_rd_data,
  output logic                o_mem_rd_data_req,
  output logic                o_busy,
  output logic [1:0]          o_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                pend0;
  logic                pend1;
  logic [ADDRS_DW-1:0] sh_addrs0;
  logic [ADDRS_DW-1:0] sh_lengths0;
  logic [ADDRS_DW-1:0] sh_addrs1;
  logic [ADDRS_DW-1:0] sh_lengths1;
  logic                owner;
  logic                grant0;
  logic                grant1;
  logic [ADDRS_DW-1:0] beat_cnt;
  logic [ADDRS_DW-1:0] mem_addrs;
  logic [ADDRS_DW-1:0] mem_lengths;
  logic [1:0]          ovf;
  logic                prefer1;
  logic                sel;
  logic                clr0;
  logic                clr1;
  logic                issue;
  logic                beat;
  logic                last_beat;
  logic                owner_data_req;

`ifdef MEM_RD_ARB_ROUND_ROBIN_EN
  // Remembers who finished the last burst so the other side wins the next contention.
  logic last_owner;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_owner <= 1'b1;
    end else if (last_beat) begin
      last_owner <= owner;
    end
  end

  assign prefer1 = ~last_owner;
`else
  assign prefer1 = 1'b0;
`endif

  assign owner_data_req = owner ? i_req1_data_req : i_req0_data_req;

  // Next-state logic: arbitration and zero-length drop in IDLE, beat counting in XFER.
  always_comb begin
    state_nxt = state;
    sel       = owner;
    clr0      = 1'b0;
    clr1      = 1'b0;
    issue     = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          sel  = pend1 && (!pend0 || prefer1);
          clr0 = ~sel;
          clr1 = sel;
          if ((sel ? sh_lengths1 : sh_lengths0) != '0) begin
            issue     = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_XFER;
      end
      ST_XFER: begin
        beat = owner_data_req;
        if (beat && (beat_cnt == mem_lengths - ADDRS_DW'(1))) begin
          last_beat = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new start always lands in the shadow registers; the active burst uses its own copy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      sh_addrs0   <= '0;
      sh_lengths0 <= '0;
      sh_addrs1   <= '0;
      sh_lengths1 <= '0;
      ovf         <= 2'b00;
    end else begin
      pend0 <= (pend0 & ~clr0) | i_req0_start;
      pend1 <= (pend1 & ~clr1) | i_req1_start;
      ovf   <= {i_req1_start & (pend1 | grant1), i_req0_start & (pend0 | grant0)};
      if (i_req0_start) begin
        sh_addrs0   <= i_req0_addrs;
        sh_lengths0 <= i_req0_lengths;
      end
      if (i_req1_start) begin
        sh_addrs1   <= i_req1_addrs;
        sh_lengths1 <= i_req1_lengths;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner       <= 1'b0;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      beat_cnt    <= '0;
      mem_addrs   <= '0;
      mem_lengths <= '0;
    end else begin
      if (issue) begin
        owner       <= sel;
        grant0      <= ~sel;
        grant1      <= sel;
        mem_addrs   <= sel ? sh_addrs1 : sh_addrs0;
        mem_lengths <= sel ? sh_lengths1 : sh_lengths0;
      end
      if (last_beat) begin
        grant0   <= 1'b0;
        grant1   <= 1'b0;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + ADDRS_DW'(1);
      end
    end
  end

  assign o_req0_grant      = grant0;
  assign o_req1_grant      = grant1;
  assign o_req0_data       = grant0 ? i_mem_rd_data : IDLE_DATA;
  assign o_req1_data       = grant1 ? i_mem_rd_data : IDLE_DATA;
  assign o_mem_rd_start    = (state == ST_ISSUE);
  assign o_mem_rd_addrs    = mem_addrs;
  assign o_mem_rd_lengths  = mem_lengths;
  assign o_mem_rd_data_req = (state == ST_XFER) && owner_data_req;
  assign o_busy            = (state != ST_IDLE);
  assign o_ovf             = ovf;

endmodule
